oled_frame_ctrl: RTL and testbench
==================================

Name: oled_frame_ctrl

Overview:
- Sequencer that drives the byte-level SPI master for the SSD1306-class OLED.
- Performs the power-on sequence: reset pulse, delay, init command list.
- On each refresh request, streams a 128x8-page frame buffer to the panel with the correct D/C per byte.
- Sits between the display logic (frame buffer, refresh trigger) and the SPI master's spi_send / spi_data_out / dc_in / spi_send_done handshake.

Parameters:
- RES_LOW_CYC, 10000: clk cycles oled_res is held low after reset.
- RES_WAIT_CYC, 10000: clk cycles to wait after oled_res is released, before the first command.
- INIT_LEN, 25: number of init command bytes in the ROM.
- COLS, 128: data bytes per page.
- PAGES, 8: pages per frame.
- FB_AW, 10: frame-buffer address width (log2(COLS*PAGES)).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- refresh  in  1  one-cycle request to send a full frame
- init_done  out  1  high once the init list is complete; stays high until reset
- busy  out  1  high whenever not in IDLE
- frame_done  out  1  one-cycle pulse after the last data byte of a frame
- oled_res  out  1  panel reset, active low
- fb_addr  out  FB_AW  frame-buffer read address, page*COLS+col
- fb_rd  out  1  read strobe; fb_data is valid exactly 1 clk later
- fb_data  in  8  frame-buffer read data
- spi_send  out  1  byte request to the SPI master
- spi_data_out  out  8  byte to send; held stable while spi_send or waiting
- dc_in  out  1  0 = command, 1 = data; held with spi_data_out
- spi_send_done  in  1  done level from the SPI master, one SPI bit-period wide

Behaviour:
- Reset values: oled_res=0, spi_send=0, spi_data_out=0, dc_in=0, fb_rd=0, fb_addr=0, init_done=0, busy=1, frame_done=0. State is RES_LOW.
- Byte handshake, shared by all sends, uses a sub-FSM SEND -> ACK -> RELEASE:
  - SEND: spi_send=1 with data and dc stable. Stay until a rising edge of spi_send_done is detected by a registered compare.
  - ACK: spi_send=0 on the cycle after the rising edge is detected.
  - RELEASE: wait for spi_send_done=0 before the next byte may be issued.
  - This guarantees no double-send, since the SPI master samples spi_send on its slow clock.
- RES_LOW: count RES_LOW_CYC cycles, then oled_res=1 and go to RES_WAIT.
- RES_WAIT: count RES_WAIT_CYC cycles, then go to INIT.
- INIT: send rom[0..INIT_LEN-1] with dc=0. After the last byte: init_done=1, go to IDLE.
- IDLE: busy=0. On refresh (or pending flag set): clear pending, page=0, go to PG_CMD.
- PG_CMD: send three commands with dc=0, in order: 0xB0|page, 0x00, 0x10. Then col=0, go to RD.
- RD: fb_rd=1 for one cycle with fb_addr=page*COLS+col. Next cycle, latch fb_data into spi_data_out with dc=1, then run the byte handshake.
- After each data byte:
  - If col==COLS-1 and page==PAGES-1: pulse frame_done, go to IDLE.
  - Else if col==COLS-1: page++, go to PG_CMD.
  - Otherwise: col++, go to RD.
- Counters: col is 7 bits and page is 3 bits. No wrap occurs because the terminal compares precede any increment.
- refresh while busy, or before init_done: set a one-deep pending flag. Multiple requests collapse to one frame. A pending flag set during init is honoured at IDLE entry.
- refresh coinciding with frame_done: treated as pending; the next frame starts immediately.
- Reset asserted mid-operation: all outputs return to reset values at once (asynchronously), the whole sequence restarts from RES_LOW, and pending is cleared.
- spi_send_done high on entry to SEND (stale): ignored until seen low first. The RELEASE state enforces this.

Decomposition:
- Shared package oled_pkg:
  - state encoding localparams;
  - command constants CMD_PAGE_BASE=0xB0, CMD_COL_LO=0x00, CMD_COL_HI=0x10;
  - DC_CMD=0 and DC_DATA=1.
- Sub-module oled_init_rom: combinational 8-bit x INIT_LEN lookup indexed by a 5-bit address. It holds the display-off / charge-pump / addressing-mode / display-on list.

Test Plan:
- Reset release with RES_LOW_CYC=4, RES_WAIT_CYC=4 -> oled_res low 4 clk, then high. The first spi_send appears 4 clk later with byte rom[0], dc=0. init_done rises after INIT_LEN handshakes.
- SPI master model returns done 50 clk after spi_send, high for 20 clk -> exactly one byte per request. spi_send drops the cycle after the done rise. The next spi_send is not issued until done is low.
- refresh after init_done, with fb_data=fb_addr[7:0] -> the byte stream is B0,00,10 (dc=0), then 00..7F (dc=1), B1,00,10, 80..FF, ... through page 7. Total 8*131=1048 bytes, then a single frame_done pulse with busy falling.
- refresh pulsed 3 times during a frame -> exactly one extra frame, starting the cycle after IDLE is entered.
- rst asserted during page 3 data -> spi_send=0 and oled_res=0 immediately. After release, the init sequence repeats from rom[0] and no frame runs without a new refresh.
- spi_send_done held high when a byte is issued -> no advance until done goes low then high; the byte count is unaffected.

Source files
------------

// File: rtl/oled_pkg.sv
// Shared types and constants for the SSD1306 frame sequencer.
// Holds the FSM encoding, handshake return targets and the page/column command bytes.
package oled_pkg;

   typedef enum logic [3:0] {
      ST_RES_LOW,
      ST_RES_WAIT,
      ST_INIT,
      ST_IDLE,
      ST_PG_CMD,
      ST_RD,
      ST_RD_WAIT,
      ST_RD_LATCH,
      ST_SEND,
      ST_ACK,
      ST_RELEASE
   } state_t;

   // Where the byte handshake returns to once the SPI master has released done
   typedef enum logic [1:0] {
      RET_INIT,
      RET_CMD,
      RET_DATA
   } ret_t;

   localparam logic [7:0] CMD_PAGE_BASE = 8'hB0;
   localparam logic [7:0] CMD_COL_LO    = 8'h00;
   localparam logic [7:0] CMD_COL_HI    = 8'h10;

   localparam logic DC_CMD  = 1'b0;
   localparam logic DC_DATA = 1'b1;

   // Byte sel of the three-command page preamble: page select, column low, column high
   function automatic logic [7:0] page_cmd(input logic [1:0] sel, input logic [2:0] page);
      case (sel)
         2'd0:    return CMD_PAGE_BASE | {5'd0, page};
         2'd1:    return CMD_COL_LO;
         default: return CMD_COL_HI;
      endcase
   endfunction

endpackage

// File: rtl/oled_init_rom.sv
// SSD1306 power-up command list: display off, timing, charge pump, page addressing, display on.
// Purely combinational; addresses past the list return a NOP.
module oled_init_rom (
   input  logic [4:0] addr,
   output logic [7:0] data
);

   always_comb begin
      data = 8'hE3;
      case (addr)
         5'd0:  data = 8'hAE;
         5'd1:  data = 8'hD5;
         5'd2:  data = 8'h80;
         5'd3:  data = 8'hA8;
         5'd4:  data = 8'h3F;
         5'd5:  data = 8'hD3;
         5'd6:  data = 8'h00;
         5'd7:  data = 8'h40;
         5'd8:  data = 8'h8D;
         5'd9:  data = 8'h14;
         5'd10: data = 8'h20;
         5'd11: data = 8'h02;
         5'd12: data = 8'hA1;
         5'd13: data = 8'hC8;
         5'd14: data = 8'hDA;
         5'd15: data = 8'h12;
         5'd16: data = 8'h81;
         5'd17: data = 8'hCF;
         5'd18: data = 8'hD9;
         5'd19: data = 8'hF1;
         5'd20: data = 8'hDB;
         5'd21: data = 8'h40;
         5'd22: data = 8'hA4;
         5'd23: data = 8'hA6;
         5'd24: data = 8'hAF;
         default: data = 8'hE3;
      endcase
   end

endmodule

// File: rtl/oled_frame_ctrl.sv
// OLED sequencer: panel reset, init command list, then full-frame streaming on refresh.
// Every byte goes through the SEND/ACK/RELEASE handshake with the slow SPI master.
module oled_frame_ctrl
   import oled_pkg::*;
#(
   parameter int unsigned RES_LOW_CYC  = 10000,
   parameter int unsigned RES_WAIT_CYC = 10000,
   parameter int unsigned INIT_LEN     = 25,
   parameter int unsigned COLS         = 128,
   parameter int unsigned PAGES        = 8,
   parameter int unsigned FB_AW        = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             refresh,
   output logic             init_done,
   output logic             busy,
   output logic             frame_done,
   output logic             oled_res,
   output logic [FB_AW-1:0] fb_addr,
   output logic             fb_rd,
   input  logic [7:0]       fb_data,
   output logic             spi_send,
   output logic [7:0]       spi_data_out,
   output logic             dc_in,
   input  logic             spi_send_done
);

   state_t      state;
   ret_t        ret;
   logic [31:0] cnt;
   logic [4:0]  idx;
   logic [1:0]  cmd_idx;
   logic [6:0]  col;
   logic [2:0]  page;
   logic        pending;
   logic        done_q;
   logic        done_rise;
   logic [7:0]  rom_data;

   oled_init_rom u_rom (
      .addr (idx),
      .data (rom_data)
   );

   // A done level already high when SEND is entered leaves done_q set, so it cannot count as a rise
   assign done_rise = spi_send_done & ~done_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= ST_RES_LOW;
         ret          <= RET_INIT;
         cnt          <= '0;
         idx          <= '0;
         cmd_idx      <= '0;
         col          <= '0;
         page         <= '0;
         pending      <= 1'b0;
         done_q       <= 1'b0;
         init_done    <= 1'b0;
         busy         <= 1'b1;
         frame_done   <= 1'b0;
         oled_res     <= 1'b0;
         fb_addr      <= '0;
         fb_rd        <= 1'b0;
         spi_send     <= 1'b0;
         spi_data_out <= '0;
         dc_in        <= DC_CMD;
      end else begin
         frame_done <= 1'b0;
         fb_rd      <= 1'b0;
         done_q     <= spi_send_done;
         if (refresh && state != ST_IDLE)
            pending <= 1'b1;

         case (state)
            ST_RES_LOW: begin
               if (cnt == RES_LOW_CYC - 1) begin
                  cnt      <= '0;
                  oled_res <= 1'b1;
                  state    <= ST_RES_WAIT;
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end

            // idx is still zero here, so the first command issues straight out of the wait
            ST_RES_WAIT: begin
               if (cnt == RES_WAIT_CYC - 1) begin
                  cnt          <= '0;
                  spi_data_out <= rom_data;
                  dc_in        <= DC_CMD;
                  spi_send     <= 1'b1;
                  ret          <= RET_INIT;
                  state        <= ST_SEND;
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end

            ST_INIT: begin
               spi_data_out <= rom_data;
               dc_in        <= DC_CMD;
               spi_send     <= 1'b1;
               ret          <= RET_INIT;
               state        <= ST_SEND;
            end

            ST_IDLE: begin
               if (refresh || pending) begin
                  pending <= 1'b0;
                  page    <= '0;
                  cmd_idx <= '0;
                  busy    <= 1'b1;
                  state   <= ST_PG_CMD;
               end
            end

            ST_PG_CMD: begin
               spi_data_out <= page_cmd(cmd_idx, page);
               dc_in        <= DC_CMD;
               spi_send     <= 1'b1;
               ret          <= RET_CMD;
               state        <= ST_SEND;
            end

            ST_RD: begin
               fb_rd   <= 1'b1;
               fb_addr <= FB_AW'(page) * FB_AW'(COLS) + FB_AW'(col);
               state   <= ST_RD_WAIT;
            end

            ST_RD_WAIT: state <= ST_RD_LATCH;

            ST_RD_LATCH: begin
               spi_data_out <= fb_data;
               dc_in        <= DC_DATA;
               spi_send     <= 1'b1;
               ret          <= RET_DATA;
               state        <= ST_SEND;
            end

            ST_SEND: begin
               if (done_rise) begin
                  spi_send <= 1'b0;
                  state    <= ST_ACK;
               end
            end

            ST_ACK: state <= ST_RELEASE;

            ST_RELEASE: begin
               if (!spi_send_done) begin
                  case (ret)
                     RET_INIT: begin
                        if (idx == 5'(INIT_LEN - 1)) begin
                           init_done <= 1'b1;
                           busy      <= 1'b0;
                           state     <= ST_IDLE;
                        end else begin
                           idx   <= idx + 5'd1;
                           state <= ST_INIT;
                        end
                     end
                     RET_CMD: begin
                        if (cmd_idx == 2'd2) begin
                           col   <= '0;
                           state <= ST_RD;
                        end else begin
                           cmd_idx <= cmd_idx + 2'd1;
                           state   <= ST_PG_CMD;
                        end
                     end
                     default: begin
                        if (col == 7'(COLS - 1) && page == 3'(PAGES - 1)) begin
                           frame_done <= 1'b1;
                           busy       <= 1'b0;
                           state      <= ST_IDLE;
                        end else if (col == 7'(COLS - 1)) begin
                           page    <= page + 3'd1;
                           cmd_idx <= '0;
                           state   <= ST_PG_CMD;
                        end else begin
                           col   <= col + 7'd1;
                           state <= ST_RD;
                        end
                     end
                  endcase
               end
            end

            default: state <= ST_RES_LOW;
         endcase
      end
   end

endmodule

// File: tb/tb_oled_frame_ctrl.sv
// Directed bench for oled_frame_ctrl with an SPI master model, frame-buffer model and byte scoreboard.
module tb_oled_frame_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       refresh = 1'b0;
   logic       init_done, busy, frame_done, oled_res, fb_rd, spi_send, dc_in;
   logic [9:0] fb_addr;
   logic [7:0] fb_data = 8'h00;
   logic [7:0] spi_data_out;
   logic       spi_send_done = 1'b0;

   int checks = 0;
   int errors = 0;
   int frames = 0;
   int lat = 50;
   int wid = 20;
   logic stale_req = 1'b0;
   logic stale_used = 1'b0;
   logic send_prev = 1'b0;
   int mn;
   logic [8:0] sb[$];
   logic [8:0] exp_byte;
   logic [7:0] rom_exp [25] = '{8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40,
                                8'h8D, 8'h14, 8'h20, 8'h02, 8'hA1, 8'hC8, 8'hDA, 8'h12,
                                8'h81, 8'hCF, 8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF};

   oled_frame_ctrl #(
      .RES_LOW_CYC  (4),
      .RES_WAIT_CYC (4)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .refresh       (refresh),
      .init_done     (init_done),
      .busy          (busy),
      .frame_done    (frame_done),
      .oled_res      (oled_res),
      .fb_addr       (fb_addr),
      .fb_rd         (fb_rd),
      .fb_data       (fb_data),
      .spi_send      (spi_send),
      .spi_data_out  (spi_data_out),
      .dc_in         (dc_in),
      .spi_send_done (spi_send_done)
   );

   always #5 clk = ~clk;

   always @(posedge clk)
      if (fb_rd) fb_data <= fb_addr[7:0];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   task automatic push_rom();
      for (int i = 0; i < 25; i++) sb.push_back({1'b0, rom_exp[i]});
   endtask

   task automatic push_frame();
      for (int p = 0; p < 8; p++) begin
         sb.push_back({1'b0, 8'hB0 | 8'(p)});
         sb.push_back(9'h000);
         sb.push_back(9'h010);
         for (int c = 0; c < 128; c++) sb.push_back({1'b1, 8'(p * 128 + c)});
      end
   endtask

   task automatic pulse_refresh();
      @(negedge clk) refresh = 1'b1;
      @(negedge clk) refresh = 1'b0;
   endtask

   task automatic wait_frame_done(input string tag);
      int n = 0;
      while (!frame_done && n < 20000) begin
         @(negedge clk);
         n++;
      end
      chk(tag, frame_done, 1);
   endtask

   task automatic respond();
      spi_send_done = 1'b1;
      @(negedge clk);
      chk("send_drop_after_done", spi_send, 0);
      repeat (wid - 1) @(negedge clk);
      spi_send_done = 1'b0;
   endtask

   // SPI master model: done rises lat clocks after a request and stays high wid clocks
   always begin
      @(negedge clk);
      if (stale_req && !stale_used) begin
         stale_used = 1'b1;
         spi_send_done = 1'b1;
         mn = 0;
         while (!spi_send && mn < 20000) begin
            @(negedge clk);
            mn++;
         end
         repeat (30) @(negedge clk);
         chk("stale_stall_send", spi_send, 1);
         chk("stale_stall_byte", {dc_in, spi_data_out}, 9'h0B0);
         spi_send_done = 1'b0;
         repeat (20) @(negedge clk);
         respond();
      end else if (spi_send) begin
         repeat (lat) @(negedge clk);
         respond();
      end
   end

   // Byte monitor: every new request is popped against the scoreboard
   always @(negedge clk) begin
      if (spi_send && !send_prev) begin
         chk("send_while_done_high", spi_send_done && !stale_req, 0);
         chk("byte_expected", 32'(sb.size() != 0), 1);
         if (sb.size() != 0) begin
            exp_byte = sb.pop_front();
            chk("byte_dc_data", {dc_in, spi_data_out}, exp_byte);
         end
      end
      send_prev = spi_send;
      if (frame_done) frames++;
   end

   initial begin
      int n;
      repeat (3) @(negedge clk);
      chk("rst_oled_res", oled_res, 0);
      chk("rst_spi_send", spi_send, 0);
      chk("rst_spi_data", spi_data_out, 0);
      chk("rst_dc", dc_in, 0);
      chk("rst_fb_rd", fb_rd, 0);
      chk("rst_fb_addr", fb_addr, 0);
      chk("rst_init_done", init_done, 0);
      chk("rst_busy", busy, 1);
      chk("rst_frame_done", frame_done, 0);

      push_rom();
      rst = 1'b1;
      n = 0;
      while (!oled_res && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk("res_low_cycles", n, 4);
      n = 0;
      while (!spi_send && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk("first_send_delay", n, 4);
      chk("first_byte", {dc_in, spi_data_out}, 9'h0AE);
      @(negedge clk);

      // refresh during init is held pending and honoured once IDLE is reached
      pulse_refresh();
      push_frame();
      n = 0;
      while (!init_done && n < 5000) begin
         @(negedge clk);
         n++;
      end
      chk("init_done_rise", init_done, 1);
      chk("init_bytes_consumed", sb.size(), 1048);
      lat = 2;
      wid = 2;
      wait_frame_done("frame1_done");
      chk("frame1_busy_low", busy, 0);
      chk("frame1_all_bytes", sb.size(), 0);
      @(negedge clk);
      chk("frame_done_one_cycle", frame_done, 0);
      chk("frame_count_1", frames, 1);

      // three refreshes mid-frame collapse into one extra frame
      pulse_refresh();
      push_frame();
      repeat (300) @(negedge clk);
      pulse_refresh();
      pulse_refresh();
      pulse_refresh();
      push_frame();
      wait_frame_done("frame2_done");
      @(negedge clk);
      chk("pending_frame_starts", busy, 1);
      wait_frame_done("frame3_done");
      repeat (200) @(negedge clk);
      chk("idle_after_frame3", busy, 0);
      chk("frame3_all_bytes", sb.size(), 0);
      chk("frame_count_3", frames, 3);

      // reset in the middle of page 3 data
      pulse_refresh();
      push_frame();
      n = 0;
      while (!(spi_send && dc_in && fb_addr[9:7] == 3'd3) && n < 20000) begin
         @(negedge clk);
         n++;
      end
      chk("reached_page3", 32'(n < 20000), 1);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("async_rst_spi_send", spi_send, 0);
      chk("async_rst_oled_res", oled_res, 0);
      chk("async_rst_init_done", init_done, 0);
      chk("async_rst_busy", busy, 1);
      sb.delete();
      push_rom();
      repeat (20) @(negedge clk);
      rst = 1'b1;
      n = 0;
      while (!init_done && n < 5000) begin
         @(negedge clk);
         n++;
      end
      chk("reinit_done", init_done, 1);
      repeat (300) @(negedge clk);
      chk("no_frame_after_rst", busy, 0);
      chk("reinit_all_bytes", sb.size(), 0);
      chk("frame_count_after_rst", frames, 3);

      // done already high when the first byte of a frame is issued
      stale_req = 1'b1;
      repeat (5) @(negedge clk);
      pulse_refresh();
      push_frame();
      wait_frame_done("stale_frame_done");
      chk("stale_frame_all_bytes", sb.size(), 0);
      stale_req = 1'b0;
      @(negedge clk);
      chk("frame_count_4", frames, 4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
